// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/execute requesters, the arbiter and the single shared memory port.
interface mem_port_arbiter_if #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
);
  logic                 fetch_readEn;
  logic [ADDR_SIZE-1:0] fetch_readAddr;
  logic                 fetch_readFin;
  logic [XLEN-1:0]      fetch_readData;
  logic                 fetch_flush;

  logic                 exec_readEn;
  logic [ADDR_SIZE-1:0] exec_readAddr;
  logic                 exec_readFin;
  logic [XLEN-1:0]      exec_readData;
  logic                 exec_writeEn;
  logic [ADDR_SIZE-1:0] exec_writeAddr;
  logic [XLEN-1:0]      exec_writeData;

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [XLEN-1:0]      mem_wdata;
  logic                 mem_ack;
  logic [XLEN-1:0]      mem_rdata;

  logic                 wbuf_valid;
  logic                 err_timeout;
  logic                 err_overflow;

  modport slave (
    input  fetch_readEn, fetch_readAddr, fetch_flush,
    input  exec_readEn, exec_readAddr, exec_writeEn, exec_writeAddr, exec_writeData,
    input  mem_ack, mem_rdata,
    output fetch_readFin, fetch_readData, exec_readFin, exec_readData,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output wbuf_valid, err_timeout, err_overflow
  );

  modport master (
    output fetch_readEn, fetch_readAddr, fetch_flush,
    output exec_readEn, exec_readAddr, exec_writeEn, exec_writeAddr, exec_writeData,
    output mem_ack, mem_rdata,
    input  fetch_readFin, fetch_readData, exec_readFin, exec_readData,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  wbuf_valid, err_timeout, err_overflow
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one memory port between a posted write buffer, execute reads and fetch reads,
// with a bounded wait for mem_ack and sticky timeout/overflow flags.
module mem_port_arbiter #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32,
  parameter int TIMEOUT   = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH_RD, EXEC_RD, EXEC_WR} state_t;

  localparam logic [7:0] WAIT_MAX  = 8'(TIMEOUT);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [ADDR_SIZE-1:0] r_addr;
  logic                 r_abort;
  logic [7:0]           r_waitCnt;
  logic                 r_wbufValid;
  logic [ADDR_SIZE-1:0] r_wbufAddr;
  logic [XLEN-1:0]      r_wbufData;
  logic                 r_errTimeout;
  logic                 r_errOverflow;

  logic                 w_busy;
  logic                 w_ack;
  logic                 w_timeout;
  logic                 w_drain;
  logic                 w_capture;
  logic                 w_overflow;

  logic                 w_memReq;
  logic                 w_memWe;
  logic [ADDR_SIZE-1:0] w_memAddr;
  logic [XLEN-1:0]      w_memWdata;
  logic                 w_execFin;
  logic                 w_fetchFin;

  assign w_busy     = (r_state != IDLE);
  assign w_ack      = w_busy & bus.mem_ack;
  assign w_timeout  = w_busy & ~bus.mem_ack & (r_waitCnt >= WAIT_LAST);
  // A write may refill the buffer in the very cycle its previous contents are acked.
  assign w_drain    = (r_state == EXEC_WR) & bus.mem_ack;
  assign w_capture  = bus.exec_writeEn & (~r_wbufValid | w_drain);
  assign w_overflow = bus.exec_writeEn & r_wbufValid & ~w_drain;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (r_wbufValid)           w_nextState = EXEC_WR;
        else if (bus.exec_readEn)  w_nextState = EXEC_RD;
        else if (bus.fetch_readEn) w_nextState = FETCH_RD;
      end
      default: begin
        if (w_ack | w_timeout) w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_abort       <= 1'b0;
      r_waitCnt     <= '0;
      r_wbufValid   <= 1'b0;
      r_wbufAddr    <= '0;
      r_wbufData    <= '0;
      r_errTimeout  <= 1'b0;
      r_errOverflow <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_waitCnt <= '0;
        if (w_nextState == EXEC_RD)       r_addr <= bus.exec_readAddr;
        else if (w_nextState == FETCH_RD) r_addr <= bus.fetch_readAddr;
      end else if (~bus.mem_ack && (r_waitCnt != WAIT_MAX)) begin
        r_waitCnt <= r_waitCnt + 8'd1;
      end

      if (w_nextState == IDLE)                         r_abort <= 1'b0;
      else if ((r_state == FETCH_RD) && bus.fetch_flush) r_abort <= 1'b1;

      if (w_capture) begin
        r_wbufValid <= 1'b1;
        r_wbufAddr  <= bus.exec_writeAddr;
        r_wbufData  <= bus.exec_writeData;
      end else if (w_drain || (w_timeout && (r_state == EXEC_WR))) begin
        r_wbufValid <= 1'b0;
      end

      if (w_timeout)  r_errTimeout  <= 1'b1;
      if (w_overflow) r_errOverflow <= 1'b1;
    end
  end

  // Outputs are gated by rst so a transaction in flight is dropped in the same cycle reset appears.
  always_comb begin
    w_memReq   = 1'b0;
    w_memWe    = 1'b0;
    w_memAddr  = '0;
    w_memWdata = '0;
    w_execFin  = 1'b0;
    w_fetchFin = 1'b0;
    if (!rst) begin
      case (r_state)
        FETCH_RD: begin
          w_memReq   = 1'b1;
          w_memAddr  = r_addr;
          w_fetchFin = bus.mem_ack & ~r_abort & ~bus.fetch_flush;
        end
        EXEC_RD: begin
          w_memReq  = 1'b1;
          w_memAddr = r_addr;
          w_execFin = bus.mem_ack;
        end
        EXEC_WR: begin
          w_memReq   = 1'b1;
          w_memWe    = 1'b1;
          w_memAddr  = r_wbufAddr;
          w_memWdata = r_wbufData;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req        = w_memReq;
  assign bus.mem_we         = w_memWe;
  assign bus.mem_addr       = w_memAddr;
  assign bus.mem_wdata      = w_memWdata;
  assign bus.exec_readFin   = w_execFin;
  assign bus.exec_readData  = w_execFin ? bus.mem_rdata : '0;
  assign bus.fetch_readFin  = w_fetchFin;
  assign bus.fetch_readData = w_fetchFin ? bus.mem_rdata : '0;
  assign bus.wbuf_valid     = r_wbufValid & ~rst;
  assign bus.err_timeout    = r_errTimeout & ~rst;
  assign bus.err_overflow   = r_errOverflow & ~rst;

endmodule
